// File: rtl/m_wbled_pwm_pkg.sv
// Shared definitions for the m_wbled_pwm LED/GPIO channel controller:
// register word indices, channel mode encodings and a byte-lane merge helper.
package m_wbled_pwm_pkg;

  // Register word indices (byte address bits [4:2]); DUTY[i] lives at REG_DUTY0+i
  localparam logic [2:0] REG_LEVEL = 3'd0;
  localparam logic [2:0] REG_MODE  = 3'd1;
  localparam logic [2:0] REG_PRESC = 3'd2;
  localparam logic [2:0] REG_DUTY0 = 3'd3;

  // Per-channel output source, two bits per channel in the MODE register
  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_PWM    = 2'b01,
    MODE_MIR    = 2'b10,
    MODE_MIRN   = 2'b11
  } chan_mode_e;

  // Replace only the byte lanes whose select bit is set
  function automatic logic [31:0] sel_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/m_wbled_pwm_chan.sv
// m_pwm_chan: one output channel of m_wbled_pwm.
// Holds the shadow duty, the PWM comparator, a 2-flop synchroniser for the
// mirror input and the registered output mux.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            prescaler enable; PWM level forced low while 0
//   load_shadow   copy duty into shadow (period wrap step, or while disabled)
//   cnt           shared PWM counter
//   duty          programmed duty (DUTY register)
//   mode          channel mode (see chan_mode_e)
//   level         direct level (LEVEL register bit)
//   mirror_i      asynchronous input to mirror
//   pwm_o         registered channel output
import m_wbled_pwm_pkg::*;

module m_pwm_chan #(
  parameter int PWMW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            load_shadow,
  input  logic [PWMW-1:0] cnt,
  input  logic [PWMW-1:0] duty,
  input  logic [1:0]      mode,
  input  logic            level,
  input  logic            mirror_i,
  output logic            pwm_o
);

  logic [PWMW-1:0] shadow;
  logic [1:0]      mir_sync;
  logic            pwm_lvl;
  logic            out_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow   <= '0;
      mir_sync <= '0;
      pwm_o    <= 1'b0;
    end else begin
      // Shadow only changes at the wrap step, so a duty write never glitches a period
      if (load_shadow) shadow <= duty;
      mir_sync <= {mir_sync[0], mirror_i};
      pwm_o    <= out_next;
    end
  end

  always_comb begin
    pwm_lvl  = en && (cnt < shadow);
    out_next = level;
    case (mode)
      MODE_DIRECT: out_next = level;
      MODE_PWM:    out_next = pwm_lvl;
      MODE_MIR:    out_next = mir_sync[1];
      MODE_MIRN:   out_next = ~mir_sync[1];
      default:     out_next = level;
    endcase
  end

endmodule

// File: rtl/m_wbled_pwm.sv
// m_wbled_pwm: Wishbone-classic slave driving NCH output channels, each a
// direct level, PWM, or (inverted) mirror of a synchronised input.
// Ports:
//   CLK_I, RST_I          clock, synchronous active-high reset
//   CYC_I, STB_I, WE_I    Wishbone cycle / strobe / write enable
//   ADR_I                 word address (byte address bits [4:2])
//   SEL_I, DAT_I          write byte lanes and data
//   DAT_O, ACK_O          read data (valid with ACK_O), one-cycle acknowledge
//   mirror_i              asynchronous per-channel mirror inputs
//   pwm_o                 registered channel outputs
import m_wbled_pwm_pkg::*;

module m_wbled_pwm #(
  parameter int NCH    = 3,
  parameter int PWMW   = 8,
  parameter int PRESCW = 4
) (
  input  logic           CLK_I,
  input  logic           RST_I,
  input  logic           CYC_I,
  input  logic           STB_I,
  input  logic           WE_I,
  input  logic [2:0]     ADR_I,
  input  logic [3:0]     SEL_I,
  input  logic [31:0]    DAT_I,
  output logic [31:0]    DAT_O,
  output logic           ACK_O,
  input  logic [NCH-1:0] mirror_i,
  output logic [NCH-1:0] pwm_o
);

  logic [NCH-1:0]    level_r;
  logic [2*NCH-1:0]  mode_r;
  logic [PRESCW-1:0] presc_r;
  logic              en_r;
  logic [PWMW-1:0]   duty_r [NCH];

  logic [PRESCW-1:0] presc_cnt;
  logic [PWMW-1:0]   pwm_cnt;

  logic        req;
  logic [31:0] rd_data;
  logic [31:0] wr_val;
  logic        unused_wr;
  logic        step;
  logic        load_shadow;

  // ACK_O in the request term forces a gap between back-to-back transfers
  assign req = CYC_I & STB_I & ~ACK_O;

  // Read view of the addressed register; unimplemented bits and indices read 0
  always_comb begin
    rd_data = '0;
    case (ADR_I)
      REG_LEVEL: rd_data[NCH-1:0]   = level_r;
      REG_MODE:  rd_data[2*NCH-1:0] = mode_r;
      REG_PRESC: begin
        rd_data[PRESCW-1:0] = presc_r;
        rd_data[31]         = en_r;
      end
      default: begin
        for (int i = 0; i < NCH; i++) begin
          if (ADR_I == REG_DUTY0 + 3'(i)) rd_data[PWMW-1:0] = duty_r[i];
        end
      end
    endcase
  end

  // Merging against the current read view keeps deselected lanes unchanged
  assign wr_val    = sel_merge(rd_data, DAT_I, SEL_I);
  assign unused_wr = ^wr_val;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      level_r <= '0;
      mode_r  <= '0;
      presc_r <= '0;
      en_r    <= 1'b0;
      for (int i = 0; i < NCH; i++) duty_r[i] <= '0;
      ACK_O   <= 1'b0;
      DAT_O   <= '0;
    end else begin
      ACK_O <= req;
      if (req) DAT_O <= rd_data;
      if (req && WE_I) begin
        case (ADR_I)
          REG_LEVEL: level_r <= wr_val[NCH-1:0];
          REG_MODE:  mode_r  <= wr_val[2*NCH-1:0];
          REG_PRESC: begin
            presc_r <= wr_val[PRESCW-1:0];
            en_r    <= wr_val[31];
          end
          default: begin
            for (int i = 0; i < NCH; i++) begin
              if (ADR_I == REG_DUTY0 + 3'(i)) duty_r[i] <= wr_val[PWMW-1:0];
            end
          end
        endcase
      end
    end
  end

  // Prescaler down-counter; terminal count advances the shared PWM counter
  assign step        = en_r && (presc_cnt == '0);
  assign load_shadow = ~en_r | (step & (&pwm_cnt));

  always_ff @(posedge CLK_I) begin
    if (RST_I || !en_r) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else if (step) begin
      presc_cnt <= presc_r;
      pwm_cnt   <= pwm_cnt + 1'b1;
    end else begin
      presc_cnt <= presc_cnt - 1'b1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    m_pwm_chan #(.PWMW(PWMW)) u_chan (
      .clk         (CLK_I),
      .rst         (RST_I),
      .en          (en_r),
      .load_shadow (load_shadow),
      .cnt         (pwm_cnt),
      .duty        (duty_r[g]),
      .mode        (mode_r[2*g +: 2]),
      .level       (level_r[g]),
      .mirror_i    (mirror_i[g]),
      .pwm_o       (pwm_o[g])
    );
  end

endmodule

// File: tb/tb_m_wbled_pwm.sv
module tb_m_wbled_pwm;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic        CYC_I = 1'b0;
  logic        STB_I = 1'b0;
  logic        WE_I  = 1'b0;
  logic [2:0]  ADR_I = '0;
  logic [3:0]  SEL_I = '0;
  logic [31:0] DAT_I = '0;
  logic [31:0] DAT_O;
  logic        ACK_O;
  logic [2:0]  mirror_i = '0;
  logic [2:0]  pwm_o;

  int total = 0;
  int bad   = 0;

  always #5 CLK_I = ~CLK_I;

  m_wbled_pwm #(.NCH(3), .PWMW(8), .PRESCW(4)) dut (
    .CLK_I    (CLK_I),
    .RST_I    (RST_I),
    .CYC_I    (CYC_I),
    .STB_I    (STB_I),
    .WE_I     (WE_I),
    .ADR_I    (ADR_I),
    .SEL_I    (SEL_I),
    .DAT_I    (DAT_I),
    .DAT_O    (DAT_O),
    .ACK_O    (ACK_O),
    .mirror_i (mirror_i),
    .pwm_o    (pwm_o)
  );

  typedef struct {
    logic        we;
    logic [2:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_rd;
    logic [2:0]  exp_pwm;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One transfer; returns with the sample taken 1ns after the edge following the commit edge
  task automatic wb_xfer(input logic we, input logic [2:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic ack, output logic [31:0] rdat);
    @(negedge CLK_I);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = dat; SEL_I = sel;
    @(posedge CLK_I);
    #1;
    ack  = ACK_O;
    rdat = DAT_O;
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    @(posedge CLK_I);
    #1;
  endtask

  task automatic wr(input string nm, input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic a;
    logic [31:0] d;
    wb_xfer(1'b1, adr, dat, sel, a, d);
    chk(nm, {31'd0, a}, 32'd1);
  endtask

  // Count samples of pwm_o[0] until the next 0->1 transition
  task automatic count_to_rise(output int highs, output int cycles);
    logic prev;
    highs = 0;
    cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      prev = pwm_o[0];
      if (prev) highs++;
      cycles++;
      @(posedge CLK_I);
      #1;
      if (!prev && pwm_o[0]) return;
    end
    cycles = -1;
    highs = -1;
  endtask

  task automatic count_n(input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      if (pwm_o[0]) highs++;
      @(posedge CLK_I);
      #1;
    end
  endtask

  initial begin
    logic        a;
    logic [31:0] d;
    int          h, c, acks;

    vecs.push_back('{1'b1, 3'd0, 32'h0000_0005, 4'b0001, 32'h0, 3'b101});
    vecs.push_back('{1'b0, 3'd0, 32'h0,         4'b0000, 32'h5, 3'b101});
    vecs.push_back('{1'b1, 3'd0, 32'hFFFF_FF02, 4'b0001, 32'h0, 3'b010});
    vecs.push_back('{1'b1, 3'd0, 32'h0000_0007, 4'b0000, 32'h0, 3'b010});
    vecs.push_back('{1'b0, 3'd0, 32'h0,         4'b0000, 32'h2, 3'b010});
    vecs.push_back('{1'b1, 3'd1, 32'h0000_FF00, 4'b0001, 32'h0, 3'b010});
    vecs.push_back('{1'b0, 3'd1, 32'h0,         4'b0000, 32'h0, 3'b010});
    vecs.push_back('{1'b1, 3'd2, 32'h8000_00AB, 4'b0001, 32'h0, 3'b010});
    vecs.push_back('{1'b1, 3'd2, 32'hFFFF_FFFF, 4'b0010, 32'h0, 3'b010});
    vecs.push_back('{1'b0, 3'd2, 32'h0,         4'b0000, 32'hB, 3'b010});
    vecs.push_back('{1'b1, 3'd7, 32'hFFFF_FFFF, 4'b1111, 32'h0, 3'b010});
    vecs.push_back('{1'b0, 3'd7, 32'h0,         4'b0000, 32'h0, 3'b010});
    vecs.push_back('{1'b1, 3'd3, 32'h0000_1234, 4'b0011, 32'h0, 3'b010});
    vecs.push_back('{1'b0, 3'd3, 32'h0,         4'b0000, 32'h34, 3'b010});
    vecs.push_back('{1'b1, 3'd5, 32'h0000_00AA, 4'b0001, 32'h0, 3'b010});
    vecs.push_back('{1'b0, 3'd5, 32'h0,         4'b0000, 32'hAA, 3'b010});
    vecs.push_back('{1'b0, 3'd6, 32'h0,         4'b0000, 32'h0, 3'b010});
    vecs.push_back('{1'b0, 3'd4, 32'h0,         4'b0000, 32'h0, 3'b010});
    vecs.push_back('{1'b1, 3'd1, 32'h0000_00FF, 4'b0001, 32'h0, 3'b111});
    vecs.push_back('{1'b0, 3'd1, 32'h0,         4'b0000, 32'h3F, 3'b111});
    vecs.push_back('{1'b1, 3'd1, 32'h0,         4'b1111, 32'h0, 3'b010});

    repeat (3) @(posedge CLK_I);
    @(negedge CLK_I);
    RST_I = 1'b0;
    chk("reset pwm_o", {29'd0, pwm_o}, 32'h0);
    chk("reset ACK_O", {31'd0, ACK_O}, 32'h0);
    chk("reset DAT_O", DAT_O, 32'h0);

    // Register access table
    foreach (vecs[i]) begin
      wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, a, d);
      chk($sformatf("vec%0d ack", i), {31'd0, a}, 32'd1);
      if (!vecs[i].we) chk($sformatf("vec%0d rdata", i), d, vecs[i].exp_rd);
      chk($sformatf("vec%0d pwm_o", i), {29'd0, pwm_o}, {29'd0, vecs[i].exp_pwm});
    end

    // Held strobe: acknowledged every other cycle
    @(negedge CLK_I);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 3'd0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK_I);
      #1;
      acks += int'(ACK_O);
    end
    CYC_I = 1'b0; STB_I = 1'b0;
    chk("back-to-back acks", acks, 2);
    @(posedge CLK_I);
    #1;

    // PWM duty 64, PRESC 0
    wr("duty0=64", 3'd3, 32'h40, 4'b0001);
    wr("mode ch0 pwm", 3'd1, 32'h01, 4'b0001);
    wr("presc0 en", 3'd2, 32'h8000_0000, 4'b1111);
    count_to_rise(h, c);
    count_to_rise(h, c);
    chk("period duty64", c, 256);
    chk("highs duty64", h, 64);

    // Duty write mid-period: current period keeps old duty
    repeat (100) begin @(posedge CLK_I); #1; end
    wr("duty0=192 mid", 3'd3, 32'hC0, 4'b0001);
    count_to_rise(h, c);
    chk("rest of old period highs", h, 0);
    count_to_rise(h, c);
    chk("period duty192", c, 256);
    chk("highs duty192", h, 192);
    repeat (200) begin @(posedge CLK_I); #1; end
    wr("duty0=64 mid", 3'd3, 32'h40, 4'b0001);
    count_to_rise(h, c);
    count_to_rise(h, c);
    chk("highs back to 64", h, 64);

    // Duty write committed exactly on the wrap step: shadow takes the old value
    repeat (254) @(posedge CLK_I);
    wr("duty0=192 at wrap", 3'd3, 32'hC0, 4'b0001);
    count_n(256, h);
    chk("wrap period keeps 64", h, 64);
    count_n(256, h);
    chk("next period uses 192", h, 192);

    // Mirror and inverted mirror on channel 1
    wr("mode ch1 mirror", 3'd1, 32'h09, 4'b0001);
    chk("mirror idle", {31'd0, pwm_o[1]}, 32'd0);
    @(negedge CLK_I);
    mirror_i[1] = 1'b1;
    @(posedge CLK_I); #1;
    chk("mirror edge1", {31'd0, pwm_o[1]}, 32'd0);
    @(posedge CLK_I); #1;
    chk("mirror edge2", {31'd0, pwm_o[1]}, 32'd0);
    @(posedge CLK_I); #1;
    chk("mirror edge3", {31'd0, pwm_o[1]}, 32'd1);
    wr("mode ch1 mirn", 3'd1, 32'h0D, 4'b0001);
    chk("mirn of 1", {31'd0, pwm_o[1]}, 32'd0);
    @(negedge CLK_I);
    mirror_i[1] = 1'b0;
    @(posedge CLK_I); #1;
    @(posedge CLK_I); #1;
    chk("mirn edge2", {31'd0, pwm_o[1]}, 32'd0);
    @(posedge CLK_I); #1;
    chk("mirn edge3", {31'd0, pwm_o[1]}, 32'd1);

    // Reset coinciding with a request: no ACK, no write
    wr("mode direct", 3'd1, 32'h0, 4'b0001);
    @(negedge CLK_I);
    RST_I = 1'b1;
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 3'd0; DAT_I = 32'h5; SEL_I = 4'b0001;
    @(posedge CLK_I); #1;
    chk("no ack in reset", {31'd0, ACK_O}, 32'd0);
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    @(negedge CLK_I);
    RST_I = 1'b0;
    wb_xfer(1'b0, 3'd0, 32'h0, 4'b0000, a, d);
    chk("level after dropped write", d, 32'h0);
    chk("pwm after reset", {29'd0, pwm_o}, 32'h0);

    // Duty 2^PWMW-1 and EN=0 mid-run
    wr("duty0=255", 3'd3, 32'hFF, 4'b0001);
    wr("mode ch0 pwm 2", 3'd1, 32'h01, 4'b0001);
    wr("presc0 en 2", 3'd2, 32'h8000_0000, 4'b1111);
    count_to_rise(h, c);
    count_to_rise(h, c);
    chk("period duty255", c, 256);
    chk("highs duty255", h, 255);
    repeat (10) begin @(posedge CLK_I); #1; end
    wr("en off", 3'd2, 32'h3, 4'b1111);
    chk("pwm off after en=0", {31'd0, pwm_o[0]}, 32'd0);
    count_n(300, h);
    chk("highs while disabled", h, 0);

    // Prescaler 3: period 4*256
    wr("duty0=64 b", 3'd3, 32'h40, 4'b0001);
    wr("presc3 en", 3'd2, 32'h8000_0003, 4'b1111);
    count_to_rise(h, c);
    count_to_rise(h, c);
    chk("period presc3", c, 1024);
    chk("highs presc3", h, 256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
